// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_TERM_EN to finish divide-by-zero, signed overflow and zero-dividend in one cycle.
module divider_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            FlushM,
  input  logic            IntDivE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic [XLEN-1:0] DivResultM
);

  localparam int CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  divState_t       state, nextState;
  logic [XLEN-1:0] remReg, quoReg, divisorReg;
  logic [CntW-1:0] counter;
  logic            negQ, negR, remSel;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] v, input logic isSigned);
    return (isSigned & v[XLEN-1]) ? negate(v) : v;
  endfunction

  logic            signedOp, aNeg, bNeg, divByZero, start, earlyTerm;
  logic [XLEN-1:0] absA, absB, earlyQuo, earlyRem;
  logic            unusedFunct3;

  assign unusedFunct3 = Funct3E[2];
  assign signedOp     = ~Funct3E[0];
  assign aNeg         = signedOp & ForwardedSrcAE[XLEN-1];
  assign bNeg         = signedOp & ForwardedSrcBE[XLEN-1];
  assign absA         = absVal(ForwardedSrcAE, signedOp);
  assign absB         = absVal(ForwardedSrcBE, signedOp);
  assign divByZero    = (ForwardedSrcBE == '0);
  assign start        = IntDivE & ~FlushE & (state == IDLE);
  assign DivBusyE     = start | (state == BUSY);

`ifdef DIV_EARLY_TERM_EN
  logic overflow, aZero;
  assign overflow  = signedOp & (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (ForwardedSrcBE == '1);
  assign aZero     = (ForwardedSrcAE == '0);
  assign earlyTerm = divByZero | overflow | aZero;
  // Results are loaded already sign-corrected, so negQ/negR are cleared on this path.
  assign earlyQuo  = divByZero ? '1 : (overflow ? ForwardedSrcAE : '0);
  assign earlyRem  = divByZero ? ForwardedSrcAE : '0;
`else
  assign earlyTerm = 1'b0;
  assign earlyQuo  = '0;
  assign earlyRem  = '0;
`endif

  // One restoring step: the shifted partial remainder needs XLEN+1 bits for unsigned divisors >= 2^(XLEN-1).
  logic [XLEN:0]   shiftRem;
  logic [XLEN+1:0] diff;
  logic            fits;
  logic [XLEN-1:0] nextRem, nextQuo;

  assign shiftRem = {remReg, quoReg[XLEN-1]};
  assign diff     = {1'b0, shiftRem} - {2'b00, divisorReg};
  assign fits     = ~diff[XLEN+1];
  assign nextRem  = fits ? diff[XLEN-1:0] : shiftRem[XLEN-1:0];
  assign nextQuo  = {quoReg[XLEN-2:0], fits};

  logic [XLEN-1:0] quotFinal, remFinal, finalVal;

  assign quotFinal = negQ ? negate(quoReg) : quoReg;
  assign remFinal  = negR ? negate(remReg) : remReg;
  assign finalVal  = remSel ? remFinal : quotFinal;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = earlyTerm ? DONE : BUSY;
      BUSY: begin
        if (FlushE)                       nextState = IDLE;
        else if (counter == CntW'(1))     nextState = DONE;
      end
      DONE: if (FlushE || !StallM)        nextState = IDLE;
      default:                            nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Execute-stage working registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      counter    <= '0;
      negQ       <= 1'b0;
      negR       <= 1'b0;
      remSel     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remSel  <= Funct3E[1];
            counter <= CntW'(XLEN);
            if (earlyTerm) begin
              quoReg <= earlyQuo;
              remReg <= earlyRem;
              negQ   <= 1'b0;
              negR   <= 1'b0;
            end else begin
              remReg     <= '0;
              quoReg     <= absA;
              divisorReg <= absB;
              // Divide-by-zero quotient must stay all ones regardless of dividend sign.
              negQ       <= (aNeg ^ bNeg) & ~divByZero;
              negR       <= aNeg;
            end
          end
        end
        BUSY: begin
          if (FlushE) begin
            counter <= '0;
          end else begin
            remReg  <= nextRem;
            quoReg  <= nextQuo;
            counter <= counter - CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-stage result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    DivResultM <= '0;
    else if (FlushM)                              DivResultM <= '0;
    else if ((state == DONE) && !StallM && !FlushE) DivResultM <= finalVal;
  end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter (XLEN=32): vector table, random ops against a
// behavioural model, and hand-written flush/stall/reset sequences.
module tb_divider_iter;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, StallM, FlushE, FlushM, IntDivE;
  logic [2:0]  Funct3E;
  logic [31:0] srcA, srcB;
  logic        DivBusyE;
  logic [31:0] DivResultM;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[21];

  divider_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushE(FlushE), .FlushM(FlushM),
    .IntDivE(IntDivE), .Funct3E(Funct3E), .ForwardedSrcAE(srcA), .ForwardedSrcBE(srcB),
    .DivBusyE(DivBusyE), .DivResultM(DivResultM)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int expBusy(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (a == 0) ||
              (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
`ifdef DIV_EARLY_TERM_EN
    return special ? 1 : XLEN + 1;
`else
    if (special) return XLEN + 1;
    return XLEN + 1;
`endif
  endfunction

  function automatic logic [31:0] popExp();
    if (expQ.size() == 0) return 32'hDEAD_BEEF;
    return expQ.pop_front();
  endfunction

  // Issue one divide, count DivBusyE cycles, optionally stall in DONE, then check the result.
  task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int holdStall);
    int busy;
    logic [31:0] prev;
    expQ.push_back(expRes);
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = f3; srcA = a; srcB = b;
    #1;
    busy = 0;
    while (DivBusyE && busy < 200) begin
      busy++;
      @(negedge clk);
      #1;
    end
    IntDivE = 1'b0;
    check({name, " busy_cycles"}, 32'(busy), 32'(expBusy(f3, a, b)));
    prev = DivResultM;
    if (holdStall > 0) begin
      StallM = 1'b1;
      for (int i = 0; i < holdStall; i++) begin
        @(negedge clk);
        #1;
        check({name, " stall_hold"}, DivResultM, prev);
      end
      StallM = 1'b0;
    end
    @(negedge clk);
    #1;
    check(name, DivResultM, popExp());
  endtask

  initial begin
    logic [31:0] prev, ra, rb;
    logic [2:0]  rf;

    vecs[0]  = '{"DIVU 100/7",        3'b101, 32'd100,       32'd7,         32'h0000_000E};
    vecs[1]  = '{"REMU 100/7",        3'b111, 32'd100,       32'd7,         32'h0000_0002};
    vecs[2]  = '{"DIV -7/2",          3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[3]  = '{"REM -7/2",          3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{"DIV 5/0",           3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[5]  = '{"REM 5/0",           3'b110, 32'd5,         32'd0,         32'h0000_0005};
    vecs[6]  = '{"DIVU 5/0",          3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[7]  = '{"REMU 5/0",          3'b111, 32'd5,         32'd0,         32'h0000_0005};
    vecs[8]  = '{"DIV ovf",           3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{"REM ovf",           3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{"DIV 7/-2",          3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[11] = '{"REM 7/-2",          3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001};
    vecs[12] = '{"DIVU max/1",        3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    vecs[13] = '{"REMU max/16",       3'b111, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F};
    vecs[14] = '{"DIVU 2^31/3",       3'b101, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA};
    vecs[15] = '{"REMU 2^31/3",       3'b111, 32'h8000_0000, 32'd3,         32'h0000_0002};
    vecs[16] = '{"REM -5/0",          3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[17] = '{"DIV 0/5",           3'b100, 32'd0,         32'd5,         32'h0000_0000};
    vecs[18] = '{"DIV -2^31/1",       3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000};
    vecs[19] = '{"DIVU max/max-1",    3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[20] = '{"REMU max/max-1",    3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    reset = 1'b1; StallM = 1'b0; FlushE = 1'b0; FlushM = 1'b0; IntDivE = 1'b0;
    Funct3E = 3'b000; srcA = '0; srcB = '0;
    #1;
    check("reset DivResultM", DivResultM, 32'h0);
    check("reset DivBusyE", 32'(DivBusyE), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++)
      runOp(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, 0);

    for (int i = 0; i < 8; i++) begin
      rf = {1'b1, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 15)) : $urandom >> $urandom_range(0, 28);
      runOp("random op", rf, ra, rb, refResult(rf, ra, rb), 0);
    end

    // FlushE during the 10th BUSY cycle aborts without touching DivResultM
    runOp("DIVU 77/7 pre-flush", 3'b101, 32'd77, 32'd7, 32'd11, 0);
    prev = DivResultM;
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = 3'b100; srcA = 32'd1000; srcB = 32'd7;
    repeat (10) @(negedge clk);
    FlushE = 1'b1; IntDivE = 1'b0;
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    check("flushE busy", 32'(DivBusyE), 32'h0);
    check("flushE result kept", DivResultM, prev);
    @(negedge clk);
    #1;
    check("flushE still idle", 32'(DivBusyE), 32'h0);
    check("flushE result kept later", DivResultM, prev);
    runOp("DIVU 9/3 after flush", 3'b101, 32'd9, 32'd3, 32'd3, 0);

    // StallM held three cycles in DONE
    runOp("DIVU 1000/10 stalled", 3'b101, 32'd1000, 32'd10, 32'd100, 3);
    runOp("REM -7/2 stalled", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 3);

    // FlushM clears the Memory-stage result
    @(negedge clk);
    FlushM = 1'b1;
    @(negedge clk);
    FlushM = 1'b0;
    #1;
    check("flushM clears", DivResultM, 32'h0);

    // Reset asserted mid-BUSY clears everything immediately
    runOp("DIVU 50/5", 3'b101, 32'd50, 32'd5, 32'd10, 0);
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = 3'b101; srcA = 32'd12345; srcB = 32'd3;
    repeat (5) @(negedge clk);
    reset = 1'b1; IntDivE = 1'b0;
    #1;
    check("midreset DivBusyE", 32'(DivBusyE), 32'h0);
    check("midreset DivResultM", DivResultM, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    runOp("DIV -100/7 after reset", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);

    check("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
